cache_controller: RTL and testbench
===================================

# cache_controller

Finite-state controller for a direct-mapped, write-back L1 data cache. It accepts load/store requests from the core, compares the request tag against the tag/valid/dirty state read from the L1 tag array, and sequences dirty-line write-back and line allocation through a handshaked L2 interface. It contains only control: tag storage, data arrays and the L2 itself sit outside the block and are driven through its strobes.

## Interface
Parameters:
- none; tag width is fixed at 21 bits (addr[31:11]).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- ld  in  1  load request.
- st  in  1  store request.
- addr  in  32  request address; requester holds it stable until the operation completes.
- valid  in  1  valid bit of the indexed L1 line.
- dirty  in  1  dirty bit of the indexed L1 line.
- tag_loaded  in  21  tag stored in the indexed L1 line.
- l2_ack  in  1  L2 read-data-ready acknowledge.
- write_done  in  1  L2 write-back complete acknowledge.
- hit  out  1  tag compare succeeded.
- miss  out  1  tag compare failed.
- load_ready  out  1  load data available from L1.
- write_l1  out  1  write strobe to the L1 data/tag array.
- write_l2  out  1  write-back strobe to L2.
- read_l2  out  1  line-fetch strobe to L2.
- state  out  2  current FSM state.

## Operation
- States: IDLE=2'b00, COMPARE_TAG=2'b01, WRITE_BACK=2'b10, ALLOCATE=2'b11.
- tag_match = (addr[31:11] == tag_loaded); cache_hit = valid & tag_match.
- IDLE: if ld or st is 1, latch the operation type into an internal op register (ld has priority if both are 1) and go to COMPARE_TAG; otherwise stay.
- COMPARE_TAG:
  - cache_hit: hit=1; load_ready=1 if op is load; write_l1=1 if op is store; next state IDLE.
  - not cache_hit: miss=1; next state WRITE_BACK if valid & dirty, otherwise ALLOCATE.
- WRITE_BACK: write_l2=1 every cycle in the state. If write_done=1, go to ALLOCATE; otherwise stay.
- ALLOCATE: read_l2=1 every cycle in the state. If l2_ack=1, write_l1=1 in that cycle (line fill) and go to COMPARE_TAG; otherwise stay.
- The re-compare after allocation uses the updated valid/tag_loaded inputs and completes the latched operation as a hit.
- ld/st are not sampled outside IDLE. They may drop after the request cycle.
- All outputs are combinational decodes of state, the op register and the current inputs. Every output not listed for a state is 0.
- state output always equals the state register.

## Timing
- Reset: while reset=0 at a rising edge, the state goes to IDLE and the op register clears to load. Every output is then 0 and state=2'b00. This holds from any state, including mid write-back or allocate; pending L2 handshakes are abandoned.
- Request sampled in IDLE at edge N: COMPARE_TAG during cycle N+1, and hit/miss are valid in that cycle.
- Hit latency: 1 cycle in COMPARE_TAG, then back in IDLE. A new request can be accepted on the next edge after that.
- Clean miss: COMPARE_TAG(1) -> ALLOCATE(k cycles until l2_ack) -> COMPARE_TAG(1) -> IDLE.
- Dirty miss: COMPARE_TAG -> WRITE_BACK (until write_done) -> ALLOCATE (until l2_ack) -> COMPARE_TAG -> IDLE.
- write_done is ignored outside WRITE_BACK. l2_ack is ignored outside ALLOCATE.
- If l2_ack is held high, it does not skip the re-compare.
- If the re-compare still misses (stale inputs), the miss path repeats.

## Test plan
- Reset: hold reset=0 for 2 cycles. Expect state=00 and all outputs 0. Release and keep ld=st=0: state stays 00.
- Read hit: addr=32'h0000_5800, tag_loaded=21'd11, valid=1, ld pulse for 1 cycle. Next cycle: state=01, hit=1, load_ready=1. Then state=00.
- Write hit: same setup with an st pulse. Expect state=01, hit=1, write_l1=1, load_ready=0. Then IDLE.
- Compulsory read miss: valid=0, ld=1. Expect state=01 with miss=1, then state=11 with read_l2=1 held for 3 cycles. Raise l2_ack and valid=1: write_l1=1, then state=01 with hit=1 and load_ready=1, then 00.
- Clean conflict miss: valid=1, dirty=0, tag_loaded=21'd10, ld. Expect miss=1, then ALLOCATE (not WRITE_BACK). After l2_ack with tag_loaded=21'd11, the re-compare hits.
- Dirty conflict miss on store: tag_loaded=21'd10, dirty=1, st. Expect miss, then state=10 with write_l2=1 until write_done=1, then state=11 with read_l2=1 until l2_ack=1, then state=01 with hit=1 and write_l1=1, then IDLE. Also assert reset=0 mid-WRITE_BACK in one run: state=00 on the next edge.

Source files
------------

// File: rtl/cache_controller.sv
// Control FSM for a direct-mapped, write-back L1 data cache.
// Compares the request tag against the indexed line, then sequences
// dirty write-back and line allocation over a handshaked L2 interface.
// Holds no tag or data storage; only strobes to the external arrays.
module cache_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic        ld,
    input  logic        st,
    input  logic [31:0] addr,
    input  logic        valid,
    input  logic        dirty,
    input  logic [20:0] tag_loaded,
    input  logic        l2_ack,
    input  logic        write_done,
    output logic        hit,
    output logic        miss,
    output logic        load_ready,
    output logic        write_l1,
    output logic        write_l2,
    output logic        read_l2,
    output logic [1:0]  state
);

    typedef enum logic [1:0] {
        StIdle       = 2'b00,
        StCompareTag = 2'b01,
        StWriteBack  = 2'b10,
        StAllocate   = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   op_store_q, op_store_d;  // 0 = load, 1 = store
    logic   tag_match;
    logic   cache_hit;
    logic   unused_addr;

    assign tag_match   = (addr[31:11] == tag_loaded);
    assign cache_hit   = valid & tag_match;
    // Index/offset bits select the line outside this block.
    assign unused_addr = ^addr[10:0];

    // State and latched operation type; synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StIdle;
            op_store_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_store_q <= op_store_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d    = state_q;
        op_store_d = op_store_q;
        hit        = 1'b0;
        miss       = 1'b0;
        load_ready = 1'b0;
        write_l1   = 1'b0;
        write_l2   = 1'b0;
        read_l2    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ld || st) begin
                    // Load wins when both are requested.
                    op_store_d = ~ld;
                    state_d    = StCompareTag;
                end
            end
            StCompareTag: begin
                if (cache_hit) begin
                    hit        = 1'b1;
                    load_ready = ~op_store_q;
                    write_l1   = op_store_q;
                    state_d    = StIdle;
                end else begin
                    miss    = 1'b1;
                    state_d = (valid && dirty) ? StWriteBack : StAllocate;
                end
            end
            StWriteBack: begin
                write_l2 = 1'b1;
                if (write_done) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                read_l2 = 1'b1;
                if (l2_ack) begin
                    // Line fill into L1, then re-compare with the new tag.
                    write_l1 = 1'b1;
                    state_d  = StCompareTag;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign state = state_q;

endmodule

// File: tb/tb_cache_controller.sv
// Self-checking bench for cache_controller: directed cases followed by
// randomized transactions checked against a transaction-level model that
// expands each request into its expected per-cycle output sequence.
module tb_cache_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld, st;
    logic [31:0] addr;
    logic        valid, dirty;
    logic [20:0] tag_loaded;
    logic        l2_ack, write_done;
    logic        hit, miss, load_ready, write_l1, write_l2, read_l2;
    logic [1:0]  state;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk        (clk),
        .reset      (reset),
        .ld         (ld),
        .st         (st),
        .addr       (addr),
        .valid      (valid),
        .dirty      (dirty),
        .tag_loaded (tag_loaded),
        .l2_ack     (l2_ack),
        .write_done (write_done),
        .hit        (hit),
        .miss       (miss),
        .load_ready (load_ready),
        .write_l1   (write_l1),
        .write_l2   (write_l2),
        .read_l2    (read_l2),
        .state      (state)
    );

    // Expected output vectors: {state, hit, miss, load_ready, write_l1, write_l2, read_l2}
    localparam logic [7:0] ExpIdle     = 8'b00_000000;
    localparam logic [7:0] ExpMiss     = 8'b01_010000;
    localparam logic [7:0] ExpWb       = 8'b10_000010;
    localparam logic [7:0] ExpAlWait   = 8'b11_000001;
    localparam logic [7:0] ExpAlFill   = 8'b11_000101;
    localparam logic [7:0] ExpHitLoad  = 8'b01_101000;
    localparam logic [7:0] ExpHitStore = 8'b01_100100;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample mid-cycle, after inputs driven at edge+1 have settled.
    task automatic chk(input string name, input logic [7:0] exp);
        logic [7:0] obs;
        #2;
        obs = {state, hit, miss, load_ready, write_l1, write_l2, read_l2};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", name, obs, exp);
        end
    endtask

    function automatic logic [20:0] other_tag(input logic [20:0] t);
        logic [20:0] d;
        d = 21'($urandom_range(1, 2097151));
        return t ^ d;
    endfunction

    // One complete request. Model: a hit is one compare cycle; a miss on a
    // dirty valid line spends wb_n cycles writing back, then every miss
    // round spends al_n cycles allocating; stale rounds re-miss cleanly.
    task automatic run_txn(input string name, input logic [31:0] a, input bit do_ld,
                           input bit do_st, input bit first_hit, input bit v, input bit d,
                           input int wb_n, input int al_n, input int stale, input bit hold_ack);
        logic [20:0] t;
        logic [7:0]  exp_hit;
        bit          need_wb;
        t          = a[31:11];
        exp_hit    = do_ld ? ExpHitLoad : ExpHitStore;
        addr       = a;
        ld         = do_ld;
        st         = do_st;
        valid      = v;
        dirty      = d;
        tag_loaded = (first_hit && v) ? t : other_tag(t);
        chk({name, ":idle_req"}, ExpIdle);
        tick();
        ld = 1'b0;
        st = 1'b0;
        if (first_hit && v) begin
            chk({name, ":cmp_hit"}, exp_hit);
            tick();
            chk({name, ":back_idle"}, ExpIdle);
            return;
        end
        chk({name, ":cmp_miss"}, ExpMiss);
        need_wb = v && d;
        for (int r = 0; r <= stale; r++) begin
            tick();
            if (need_wb) begin
                for (int i = 0; i < wb_n; i++) begin
                    write_done = (i == wb_n - 1);
                    l2_ack     = 1'($urandom_range(0, 1));
                    chk({name, ":wb"}, ExpWb);
                    tick();
                end
                write_done = 1'b0;
                need_wb    = 1'b0;
            end
            for (int i = 0; i < al_n; i++) begin
                l2_ack     = (i == al_n - 1);
                write_done = 1'($urandom_range(0, 1));
                if (i == al_n - 1) begin
                    valid      = 1'b1;
                    dirty      = (r < stale) ? 1'b0 : 1'($urandom_range(0, 1));
                    tag_loaded = (r < stale) ? other_tag(t) : t;
                    chk({name, ":al_fill"}, ExpAlFill);
                end else begin
                    chk({name, ":al_wait"}, ExpAlWait);
                end
                tick();
            end
            l2_ack     = hold_ack;
            write_done = 1'b0;
            if (r < stale) begin
                chk({name, ":recmp_miss"}, ExpMiss);
            end else begin
                chk({name, ":recmp_hit"}, exp_hit);
            end
        end
        tick();
        l2_ack = 1'b0;
        chk({name, ":done_idle"}, ExpIdle);
    endtask

    initial begin
        reset      = 1'b0;
        ld         = 1'b0;
        st         = 1'b0;
        addr       = '0;
        valid      = 1'b0;
        dirty      = 1'b0;
        tag_loaded = '0;
        l2_ack     = 1'b0;
        write_done = 1'b0;

        // Reset held for two edges.
        tick();
        tick();
        chk("reset", ExpIdle);
        reset = 1'b1;
        tick();
        chk("idle_quiet1", ExpIdle);
        tick();
        chk("idle_quiet2", ExpIdle);

        // Directed cases.
        run_txn("read_hit",   32'h0000_5800, 1, 0, 1, 1, 0, 0, 0, 0, 0);
        run_txn("write_hit",  32'h0000_5800, 0, 1, 1, 1, 0, 0, 0, 0, 0);
        run_txn("both_ld_pri", 32'h0000_5800, 1, 1, 1, 1, 1, 0, 0, 0, 0);
        run_txn("cold_miss",  32'h0000_5800, 1, 0, 0, 0, 0, 0, 4, 0, 0);
        run_txn("clean_miss", 32'h0000_5800, 1, 0, 0, 1, 0, 0, 2, 0, 0);
        run_txn("dirty_st",   32'h0000_5800, 0, 1, 0, 1, 1, 3, 3, 0, 0);
        run_txn("ack_held",   32'h0000_5800, 0, 1, 0, 1, 0, 0, 1, 0, 1);
        run_txn("stale",      32'h0000_5800, 1, 0, 0, 1, 1, 1, 2, 1, 0);

        // Reset mid write-back abandons the handshake.
        addr       = 32'h0000_5800;
        st         = 1'b1;
        valid      = 1'b1;
        dirty      = 1'b1;
        tag_loaded = 21'd10;
        chk("rst_wb:idle_req", ExpIdle);
        tick();
        st = 1'b0;
        chk("rst_wb:cmp_miss", ExpMiss);
        tick();
        chk("rst_wb:wb", ExpWb);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        chk("rst_wb:idle", ExpIdle);
        tick();
        chk("rst_wb:stay_idle", ExpIdle);

        // Randomized transactions.
        for (int n = 0; n < 40; n++) begin
            bit is_st, both;
            is_st = 1'($urandom_range(0, 1));
            both  = ($urandom_range(0, 5) == 0);
            run_txn($sformatf("rnd%0d", n), $urandom,
                    !is_st || both, is_st || both,
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)),
                    $urandom_range(1, 4), $urandom_range(1, 4),
                    ($urandom_range(0, 3) == 0) ? 1 : 0,
                    1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
